// File: rtl/memory_responder_pkg.sv
// memory_responder_pkg: shared types and default geometry for the memory-side
// refill/writeback responder. Default line width and physical address width
// come from the project-wide `LINE_WIDTH and `PHYS_ADDR_SIZE macros when they
// are set, otherwise from the fallbacks below.

`ifndef LINE_WIDTH
`define LINE_WIDTH 64
`endif
`ifndef PHYS_ADDR_SIZE
`define PHYS_ADDR_SIZE 32
`endif

package memory_responder_pkg;

  localparam int DEF_LINE_WIDTH  = `LINE_WIDTH;
  localparam int DEF_ADDR_SIZE   = `PHYS_ADDR_SIZE;
  localparam int DEF_DEPTH_LINES = 1024;
  localparam int DEF_LATENCY     = 4;

  // Derived geometry for the default configuration
  localparam int LINE_BYTES  = DEF_LINE_WIDTH / 8;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int INDEX_BITS  = $clog2(DEF_DEPTH_LINES);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WRITE_WAIT = 2'd1,
    S_READ_WAIT  = 2'd2,
    S_COOLDOWN   = 2'd3
  } state_t;

endpackage

// File: rtl/memory_responder_line_store.sv
// line_store: DEPTH_LINES x LINE_WIDTH backing array with a synchronous write
// port and a combinational read port. Contents are never reset; r_mem is the
// preload hook (loaders write it hierarchically before traffic starts).

module line_store
  import memory_responder_pkg::*;
#(
  parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
  parameter int DEPTH_LINES = DEF_DEPTH_LINES,
  parameter int IDX_BITS    = $clog2(DEPTH_LINES)
) (
  input  logic                  i_clock,
  input  logic                  i_we,
  input  logic [IDX_BITS-1:0]   i_w_index,
  input  logic [LINE_WIDTH-1:0] i_w_data,
  input  logic [IDX_BITS-1:0]   i_r_index,
  output logic [LINE_WIDTH-1:0] o_r_data
);

  logic [LINE_WIDTH-1:0] r_mem [DEPTH_LINES];

  // Commit one whole line on a write strobe
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_w_index] <= i_w_data;
    end
  end

  assign o_r_data = r_mem[i_r_index];

endmodule

// File: rtl/memory_responder.sv
// memory_responder: services d-cache line fills and dirty-line writebacks
// against a fixed-latency line store. One request at a time; a writeback wins
// over a simultaneous fill so the eviction lands before the refill is served.
// Optional build macro: MEMORY_RESPONDER_BOUNDS_CHECK_EN (when defined, a line
// number outside the store at acceptance is reported and simulation stops;
// otherwise the line number wraps modulo DEPTH_LINES).

module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int LINE_WIDTH  = LINE_BYTES * 8,
  parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
  parameter int DEPTH_LINES = 2 ** INDEX_BITS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cache_miss,
  input  logic                  write_from_cache,
  input  logic [ADDR_SIZE-1:0]  address,
  input  logic [LINE_WIDTH-1:0] write_data,
  output logic [LINE_WIDTH-1:0] read_data,
  output logic                  fill_valid,
  output logic                  write_done,
  output logic                  busy
);

  localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
  localparam int IDX_BITS = $clog2(DEPTH_LINES);
  localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [IDX_BITS-1:0]   r_index, w_index_nxt;
  logic [IDX_BITS-1:0]   w_req_index;
  logic [LINE_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [LINE_WIDTH-1:0] r_read_data, w_read_nxt;
  logic                  r_fill_valid, w_fill_nxt;
  logic                  r_write_done, w_done_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  w_store_we;
  logic [LINE_WIDTH-1:0] w_store_rdata;

  // Byte offset dropped; upper line-number bits wrap modulo the store depth
  assign w_req_index = IDX_BITS'(address >> OFF_BITS);

  line_store #(
    .LINE_WIDTH  (LINE_WIDTH),
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_BITS    (IDX_BITS)
  ) u_store (
    .i_clock   (clock),
    .i_we      (w_store_we),
    .i_w_index (r_index),
    .i_w_data  (r_wdata),
    .i_r_index (r_index),
    .o_r_data  (w_store_rdata)
  );

  // Next-state, latency countdown, request latching and strobe generation
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_index_nxt = r_index;
    w_wdata_nxt = r_wdata;
    w_read_nxt  = r_read_data;
    w_fill_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_store_we  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (write_from_cache) begin
          w_state_nxt = S_WRITE_WAIT;
          w_cnt_nxt   = CNT_LOAD;
          w_index_nxt = w_req_index;
          w_wdata_nxt = write_data;
        end else if (cache_miss) begin
          w_state_nxt = S_READ_WAIT;
          w_cnt_nxt   = CNT_LOAD;
          w_index_nxt = w_req_index;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE_WAIT: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_store_we  = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_COOLDOWN;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_READ_WAIT: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_read_nxt  = w_store_rdata;
          w_fill_nxt  = 1'b1;
          w_state_nxt = S_COOLDOWN;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_COOLDOWN: begin
        // Requester drops its level during this cycle; nothing is sampled
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State, latches and registered outputs; reset abandons any pending request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= {CNT_W{1'b0}};
      r_index      <= {IDX_BITS{1'b0}};
      r_wdata      <= {LINE_WIDTH{1'b0}};
      r_read_data  <= {LINE_WIDTH{1'b0}};
      r_fill_valid <= 1'b0;
      r_write_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_index      <= w_index_nxt;
      r_wdata      <= w_wdata_nxt;
      r_read_data  <= w_read_nxt;
      r_fill_valid <= w_fill_nxt;
      r_write_done <= w_done_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

`ifdef MEMORY_RESPONDER_BOUNDS_CHECK_EN
  // Stop on a request whose line number lies outside the store
  always_ff @(posedge clock) begin
    if (reset_n && (r_state == S_IDLE) && (write_from_cache || cache_miss) &&
        ((64'(address) >> OFF_BITS) >= 64'(DEPTH_LINES))) begin
      $fatal(1, "memory_responder: line out of range, address 0x%0h", address);
    end
  end
`endif

  assign read_data  = r_read_data;
  assign fill_valid = r_fill_valid;
  assign write_done = r_write_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed and randomized fill/writeback traffic checked
// against a line-indexed associative reference store and the fixed response
// latency.

module tb_memory_responder;
  import memory_responder_pkg::*;

  localparam int LW    = 64;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int LAT   = 4;
  localparam int OFF   = OFFSET_BITS;
  localparam int LB    = LINE_BYTES;

  logic          clock            = 1'b0;
  logic          reset_n          = 1'b0;
  logic          cache_miss       = 1'b0;
  logic          write_from_cache = 1'b0;
  logic [AW-1:0] address          = '0;
  logic [LW-1:0] write_data       = '0;
  logic [LW-1:0] read_data;
  logic          fill_valid;
  logic          write_done;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference store: line index -> contents of the last committed writeback
  logic [LW-1:0] model_mem [int];

  always #5 clock = ~clock;

  memory_responder #(
    .LINE_WIDTH  (LW),
    .ADDR_SIZE   (AW),
    .DEPTH_LINES (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .cache_miss       (cache_miss),
    .write_from_cache (write_from_cache),
    .address          (address),
    .write_data       (write_data),
    .read_data        (read_data),
    .fill_valid       (fill_valid),
    .write_done       (write_done),
    .busy             (busy)
  );

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [AW-1:0] line_addr(input int unsigned line);
    return (AW'(line) << OFF) | AW'($urandom_range(0, LB - 1));
  endfunction

  // One complete request: accept, scramble inputs, wait for strobe, verify
  task automatic transact(input bit is_wr, input int unsigned line,
                          input logic [LW-1:0] data, input string tag);
    int k;
    bit seen;
    int unsigned idx;
    idx        = line % DEPTH;
    address    = line_addr(line);
    write_data = data;
    if (is_wr) write_from_cache = 1'b1;
    else       cache_miss       = 1'b1;
    step();
    check({tag, " busy_after_accept"}, LW'(busy), LW'(1));
    address    = ~address;
    write_data = ~data;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < LAT + 8) begin
      step();
      k++;
      seen = is_wr ? write_done : fill_valid;
    end
    check({tag, " latency"}, LW'(k), LW'(LAT));
    check({tag, " other_strobe"}, LW'(is_wr ? fill_valid : write_done), LW'(0));
    if (is_wr) begin
      model_mem[idx] = data;
    end else begin
      check({tag, " read_data"}, read_data, model_mem[idx]);
    end
    write_from_cache = 1'b0;
    cache_miss       = 1'b0;
    step();
    check({tag, " strobe_one_cycle"}, LW'(fill_valid | write_done), LW'(0));
    check({tag, " idle_after"}, LW'(busy), LW'(0));
  endtask

  initial begin
    int j;
    int cnt;
    logic [LW-1:0] d;
    int unsigned ln;
    bit wr;

    // Reset state
    repeat (2) step();
    check("rst busy", LW'(busy), LW'(0));
    check("rst fill_valid", LW'(fill_valid), LW'(0));
    check("rst write_done", LW'(write_done), LW'(0));
    check("rst read_data", read_data, LW'(0));
    reset_n = 1'b1;
    step();

    // Line 5 set to A5 pattern, then filled by byte address 5*LINE_BYTES
    transact(1'b1, 5, {8{8'hA5}}, "wr5");
    transact(1'b0, 5, {8{8'hA5}}, "fill5");

    // Writeback 3C pattern to line 7 then fill it
    transact(1'b1, 7, {8{8'h3C}}, "wr7");
    transact(1'b0, 7, '0, "fill7");

    // Simultaneous writeback and fill to line 7: writeback first
    d                = {$urandom, $urandom};
    address          = line_addr(7);
    write_data       = d;
    write_from_cache = 1'b1;
    cache_miss       = 1'b1;
    step();
    j = 0;
    while (!write_done && j < LAT + 8) begin
      step();
      j++;
    end
    check("both wr_latency", LW'(j), LW'(LAT));
    check("both no_fill_yet", LW'(fill_valid), LW'(0));
    model_mem[7]     = d;
    write_from_cache = 1'b0;
    j = 0;
    while (!fill_valid && j < 2 * LAT + 8) begin
      step();
      j++;
    end
    check("both fill_gap", LW'(j), LW'(LAT + 2));
    check("both read_data", read_data, model_mem[7]);
    cache_miss = 1'b0;
    step();

    // Wrap: line numbers past the store alias modulo DEPTH
    transact(1'b1, 3, {$urandom, $urandom}, "wr3");
    transact(1'b0, DEPTH + 3, '0, "fill_wrap3");
    transact(1'b1, DEPTH + 11, {$urandom, $urandom}, "wr_wrap11");
    transact(1'b0, 11, '0, "fill11");

    // Request level held through cooldown must not be serviced twice
    address    = line_addr(5);
    cache_miss = 1'b1;
    step();
    j = 0;
    while (!fill_valid && j < LAT + 8) begin
      step();
      j++;
    end
    check("held latency", LW'(j), LW'(LAT));
    check("held read_data", read_data, model_mem[5]);
    step();
    cache_miss = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2 * LAT + 4; i++) begin
      if (fill_valid || busy) cnt++;
      step();
    end
    check("held no_duplicate", LW'(cnt), LW'(0));

    // Reset mid-writeback at counter 2: line 9 keeps its old contents
    transact(1'b1, 9, {$urandom, $urandom}, "wr9");
    transact(1'b0, 9, '0, "fill9");
    address          = line_addr(9);
    write_data       = ~model_mem[9];
    write_from_cache = 1'b1;
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("rst_mid busy", LW'(busy), LW'(0));
    check("rst_mid read_data", read_data, LW'(0));
    write_from_cache = 1'b0;
    step();
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      if (write_done || busy) cnt++;
      step();
    end
    check("rst_mid no_strobe", LW'(cnt), LW'(0));
    transact(1'b0, 9, '0, "rst_mid fill9");

    // Randomized traffic over a small line set, with aliasing addresses
    for (int t = 0; t < 40; t++) begin
      ln = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) ln = ln + DEPTH * $urandom_range(1, 3);
      wr = $urandom_range(0, 1) == 1;
      if (!model_mem.exists(int'(ln % DEPTH))) wr = 1'b1;
      if (wr) transact(1'b1, ln, {$urandom, $urandom}, "rnd_wr");
      else    transact(1'b0, ln, '0, "rnd_rd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
